// File: rtl/mips_cpu_hilo_seq_unit.sv
// Iterative HI/LO multiply/divide unit with MFHI/MFLO read port and stall.
// Define MIPS_HILO_FAST_MULT_EN for a single-cycle combinational multiplier.
module mips_cpu_hilo_seq_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            rd_req,
   input  logic            rd_sel,
   output logic [XLEN-1:0] rd_data,
   output logic            rd_valid,
   output logic            stall,
   output logic            busy,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

   state_t      state;
   logic [4:0]  counter;
   logic [63:0] acc;       // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
   logic [31:0] opnd;      // multiplicand or divisor magnitude
   logic        res_neg;
   logic        rem_neg;
   logic        is_mul;
   logic        div_zero;

   function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
      return (sgn && x[31]) ? -x : x;
   endfunction

   function automatic logic [63:0] cond_neg64(input logic [63:0] x, input logic neg);
      return neg ? -x : x;
   endfunction

   function automatic logic [31:0] cond_neg32(input logic [31:0] x, input logic neg);
      return neg ? -x : x;
   endfunction

   logic [32:0] mul_sum;
   logic [63:0] mul_next;
   logic [32:0] div_shift;
   logic [33:0] div_trial;
   logic [63:0] div_next;
   logic        op_signed;

   always_comb begin
      op_signed = op[1];
      mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
      mul_next  = {mul_sum, acc[31:1]};
      div_shift = {acc[63:32], acc[31]};
      div_trial = {1'b0, div_shift} - {2'b00, opnd};
      if (div_trial[33])
         div_next = {div_shift[31:0], acc[30:0], 1'b0};
      else
         div_next = {div_trial[31:0], acc[30:0], 1'b1};
   end

`ifdef MIPS_HILO_FAST_MULT_EN
   logic               fast_pend;
   logic signed [65:0] fast_a;
   logic signed [65:0] fast_b;
   logic signed [65:0] fast_prod;

   always_comb begin
      fast_a    = {{34{op_signed & a[31]}}, a};
      fast_b    = {{34{op_signed & b[31]}}, b};
      fast_prod = fast_a * fast_b;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         hi      <= '0;
         lo      <= '0;
         counter <= '0;
`ifdef MIPS_HILO_FAST_MULT_EN
         fast_pend <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
`ifdef MIPS_HILO_FAST_MULT_EN
               // Registered product lands one cycle after issue; a later MTHI/MTLO wins.
               fast_pend <= 1'b0;
               if (fast_pend) begin
                  hi <= acc[63:32];
                  lo <= acc[31:0];
               end
`endif
               if (start) begin
                  case (op)
                     3'b000, 3'b010: begin
                        acc      <= {32'd0, mag32(a, op_signed)};
                        opnd     <= mag32(b, op_signed);
                        res_neg  <= op_signed & (a[31] ^ b[31]);
                        rem_neg  <= op_signed & a[31];
                        div_zero <= (b == '0);
                        is_mul   <= 1'b0;
                        counter  <= 5'd31;
                        state    <= DIV;
                     end
                     3'b001, 3'b011: begin
`ifdef MIPS_HILO_FAST_MULT_EN
                        acc       <= fast_prod[63:0];
                        fast_pend <= 1'b1;
`else
                        acc      <= {32'd0, mag32(b, op_signed)};
                        opnd     <= mag32(a, op_signed);
                        res_neg  <= op_signed & (a[31] ^ b[31]);
                        rem_neg  <= 1'b0;
                        div_zero <= 1'b0;
                        is_mul   <= 1'b1;
                        counter  <= 5'd31;
                        state    <= MUL;
`endif
                     end
                     3'b100:  hi <= a;
                     3'b101:  lo <= a;
                     default: ;
                  endcase
               end
            end
            MUL: begin
               acc <= mul_next;
               if (counter == 5'd0) state <= FIX;
               else                 counter <= counter - 5'd1;
            end
            DIV: begin
               acc <= div_next;
               if (counter == 5'd0) state <= FIX;
               else                 counter <= counter - 5'd1;
            end
            FIX: begin
               if (is_mul) begin
                  {hi, lo} <= cond_neg64(acc, res_neg);
               end else begin
                  hi <= cond_neg32(acc[63:32], rem_neg);
                  lo <= div_zero ? 32'hFFFF_FFFF : cond_neg32(acc[31:0], res_neg);
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy     = (state != IDLE);
   assign rd_data  = rd_sel ? hi : lo;
   assign rd_valid = rd_req && !busy;
   assign stall    = rd_req && busy;

endmodule

// File: tb/tb_mips_cpu_hilo_seq_unit.sv
// Directed self-checking bench for mips_cpu_hilo_seq_unit (default iterative build).
module tb_mips_cpu_hilo_seq_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        rd_req;
   logic        rd_sel;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        stall;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_cmp = 0;
   int n_err = 0;

   mips_cpu_hilo_seq_unit #(.XLEN(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(rd_data), .rd_valid(rd_valid),
      .stall(stall), .busy(busy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   // Issue one op and wait (bounded) for busy to fall; returns busy cycle count.
   task automatic run_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                         output int cycles);
      @(negedge clk);
      start = 1'b1; op = o; a = va; b = vb;
      @(negedge clk);
      start = 1'b0;
      cycles = 0;
      while (busy && cycles < 100) begin
         cycles++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; op = 3'b110; a = '0; b = '0; rd_req = 1'b0; rd_sel = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h want 0", hi); end
      n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h want 0", lo); end
      n_cmp++; if ({rd_valid, stall} !== 2'b00) begin n_err++; $display("FAIL reset_rd: got %b want 00", {rd_valid, stall}); end
      rd_req = 1'b1;
      #1;
      n_cmp++; if ({rd_valid, stall} !== 2'b10) begin n_err++; $display("FAIL reset_rdreq: got %b want 10", {rd_valid, stall}); end
      rd_req = 1'b0;
   endtask

   task automatic test_multu();
      int cyc;
      run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
      n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL multu_busy_cycles: got %0d want 33", cyc); end
      n_cmp++; if (hi !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
      n_cmp++; if (lo !== 32'h0000_0001) begin n_err++; $display("FAIL multu_lo: got %h want 00000001", lo); end
   endtask

   task automatic test_mult();
      int cyc;
      run_op(3'b011, 32'hFFFF_FFFD, 32'd7, cyc);
      n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
      n_cmp++; if (lo !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
      run_op(3'b011, 32'h0001_0000, 32'hFFFF_0000, cyc);
      n_cmp++; if ({hi, lo} !== 64'hFFFF_FFFF_0000_0000) begin n_err++; $display("FAIL mult_neg2: got %h want ffffffff00000000", {hi, lo}); end
   endtask

   task automatic test_div();
      int cyc;
      run_op(3'b010, 32'hFFFF_FFF9, 32'd2, cyc);
      n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL div_busy_cycles: got %0d want 33", cyc); end
      n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo: got %h want fffffffd", lo); end
      n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi: got %h want ffffffff", hi); end
      run_op(3'b000, 32'd100, 32'd0, cyc);
      n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL divz_busy_cycles: got %0d want 33", cyc); end
      n_cmp++; if (hi !== 32'd100) begin n_err++; $display("FAIL divz_hi: got %h want 00000064", hi); end
      n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divz_lo: got %h want ffffffff", lo); end
      run_op(3'b000, 32'hFFFF_FFF9, 32'd2, cyc);
      n_cmp++; if ({hi, lo} !== {32'd1, 32'h7FFF_FFFC}) begin n_err++; $display("FAIL divu_big: got %h want 000000017ffffffc", {hi, lo}); end
   endtask

   task automatic test_overflow();
      int cyc;
      run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
      n_cmp++; if (lo !== 32'h8000_0000) begin n_err++; $display("FAIL ovf_lo: got %h want 80000000", lo); end
      n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL ovf_hi: got %h want 00000000", hi); end
   endtask

   task automatic test_mt_and_noop();
      int cyc;
      run_op(3'b101, 32'h0000_BEEF, 32'd0, cyc);
      n_cmp++; if (lo !== 32'h0000_BEEF) begin n_err++; $display("FAIL mtlo: got %h want 0000beef", lo); end
      n_cmp++; if (cyc !== 0) begin n_err++; $display("FAIL mtlo_busy: got %0d want 0", cyc); end
      run_op(3'b100, 32'h0000_5555, 32'd0, cyc);
      run_op(3'b110, 32'h1111_1111, 32'd3, cyc);
      run_op(3'b111, 32'h2222_2222, 32'd3, cyc);
      n_cmp++; if ({hi, lo} !== {32'h0000_5555, 32'h0000_BEEF}) begin n_err++; $display("FAIL noop_hilo: got %h want 000055550000beef", {hi, lo}); end
   endtask

   task automatic test_read_stall();
      int cyc;
      rd_req = 1'b1; rd_sel = 1'b1;
      @(negedge clk);
      start = 1'b1; op = 3'b100; a = 32'h0000_1234;
      #1;
      n_cmp++; if (rd_data !== 32'h0000_5555) begin n_err++; $display("FAIL mthi_same_cycle: got %h want 00005555", rd_data); end
      @(negedge clk);
      start = 1'b0;
      n_cmp++; if (rd_data !== 32'h0000_1234) begin n_err++; $display("FAIL mthi_next_cycle: got %h want 00001234", rd_data); end
      start = 1'b1; op = 3'b000; a = 32'd100; b = 32'd7;
      #1;
      n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL read_issue_cycle: got %b want 1", rd_valid); end
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (stall === 1'b1 && rd_valid === 1'b0 && cyc < 100) begin
         cyc++;
         @(negedge clk);
      end
      n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL stall_cycles: got %0d want 33", cyc); end
      n_cmp++; if ({rd_valid, stall} !== 2'b10) begin n_err++; $display("FAIL read_after: got %b want 10", {rd_valid, stall}); end
      n_cmp++; if (rd_data !== 32'd2) begin n_err++; $display("FAIL read_rem: got %h want 00000002", rd_data); end
      rd_sel = 1'b0;
      #1;
      n_cmp++; if (rd_data !== 32'd14) begin n_err++; $display("FAIL read_quo: got %h want 0000000e", rd_data); end
      rd_req = 1'b0;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      start = 1'b1; op = 3'b010; a = 32'hFFFF_FFF9; b = 32'd2;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b want 1", busy); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_cmp++; if ({busy, hi, lo} !== 65'd0) begin n_err++; $display("FAIL mid_reset: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo); end
      repeat (40) @(negedge clk);
      n_cmp++; if ({hi, lo} !== 64'd0) begin n_err++; $display("FAIL mid_reset_later: got %h want 0", {hi, lo}); end
   endtask

   task automatic test_back_to_back();
      int cyc;
      @(negedge clk);
      start = 1'b1; op = 3'b001; a = 32'd6; b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (busy && cyc < 100) begin
         cyc++;
         if (cyc == 5) begin start = 1'b1; op = 3'b101; a = 32'hDEAD; end
         else if (cyc == 6) begin start = 1'b1; op = 3'b000; a = 32'd9; b = 32'd2; end
         else start = 1'b0;
         @(negedge clk);
      end
      start = 1'b0;
      n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL b2b_cycles: got %0d want 33", cyc); end
      n_cmp++; if ({hi, lo} !== {32'd0, 32'd42}) begin n_err++; $display("FAIL b2b_result: got %h want 000000000000002a", {hi, lo}); end
      repeat (3) @(negedge clk);
      n_cmp++; if ({busy, lo} !== {1'b0, 32'd42}) begin n_err++; $display("FAIL b2b_idle_hold: got busy=%b lo=%h want 0/0000002a", busy, lo); end
   endtask

   initial begin
      test_reset();
      test_multu();
      test_mult();
      test_div();
      test_overflow();
      test_mt_and_noop();
      test_read_stall();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mips_cpu_hilo_seq_unit.md
Name: mips_cpu_hilo_seq_unit

Overview:
Multi-cycle HI/LO unit that replaces the single-cycle combinational multiply/divide path with an iterative engine. It also serves the read side of the HI/LO interface: MFHI/MFLO requests from the decode/execute stage receive a stall while an operation is in flight, then get a valid result. It sits in the execute stage beside the main ALU and drives the HI/LO read port of the writeback mux.

Parameters:
- XLEN, 32, operand and HI/LO register width; only 32 is supported.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  issue strobe for op; sampled on a rising edge
- op  in  3  000 DIVU, 001 MULTU, 010 DIV, 011 MULT, 100 MTHI, 101 MTLO, 110/111 no-op
- a  in  32  operand A (dividend / multiplicand / MTHI-MTLO source)
- b  in  32  operand B (divisor / multiplier)
- rd_req  in  1  MFHI/MFLO read request
- rd_sel  in  1  1 selects HI, 0 selects LO
- rd_data  out  32  selected HI or LO, combinational from the registers
- rd_valid  out  1  rd_req && !busy
- stall  out  1  rd_req && busy; pipeline hold request
- busy  out  1  operation in flight (state != IDLE)
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, counter=0, busy=0. rd_valid and stall are 0 unless rd_req is high.
- States: IDLE, MUL, DIV, FIX.
- IDLE + start + op in {000..011}:
  - latch operand magnitudes (signed ops take two's-complement magnitude) and the result signs;
  - counter=31;
  - go to MUL (op 001/011) or DIV (op 000/010).
- IDLE + start + op 100: hi<=a, single cycle, stays IDLE. op 101: lo<=a. op 110/111: no effect.
- start while busy: ignored; no state change. Issuing during busy is a CPU error.
- MUL: one shift-add step per cycle on a 64-bit accumulator. At counter==0 go to FIX; otherwise decrement.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit). At counter==0 go to FIX.
- FIX:
  - signed multiply: negate the 64-bit product if the operand signs differ;
  - signed divide: quotient negated if signs differ; remainder takes the dividend's sign;
  - write hi/lo, return to IDLE.
- Latency: start accepted at edge E0, hi/lo updated at E33, busy high for exactly 33 cycles.
- Register mapping: multiply gives hi=product[63:32], lo=product[31:0]; divide gives hi=remainder, lo=quotient.
- Divide by zero (b==0, DIV or DIVU): hi=a, lo=32'hFFFF_FFFF; still takes 33 cycles.
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0.
- Read side: rd_data always reflects the current registers. A read in the same cycle as an accepted start returns the pre-start value; this matches program order.
- hi/lo hold their values across idle cycles. Only FIX, MTHI, MTLO and reset modify them.
- Reset mid-operation: abort immediately; hi=lo=0, IDLE next cycle.

Optional Feature:
- Macro: MIPS_HILO_FAST_MULT_EN.
- Defined: MULT/MULTU compute the product with a single-cycle combinational multiplier and write hi/lo at E1. busy is never raised for multiplies; DIV/DIVU are unchanged.
- Undefined: the iterative 33-cycle multiply described above.

Test Plan:
- Reset, then MULTU a=0xFFFF_FFFF b=0xFFFF_FFFF -> busy high for 33 cycles; hi=0xFFFF_FFFE, lo=0x0000_0001 at E33.
- MULT a=-3 (0xFFFF_FFFD) b=7 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFEB.
- DIV a=-7 b=2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIVU a=100 b=0 -> hi=100, lo=0xFFFF_FFFF.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
- MTHI 0x1234 with rd_req=1, rd_sel=1 held continuously:
  - same-cycle read returns the old HI;
  - the next cycle returns 0x1234;
  - a DIVU issued next gives stall=1, rd_valid=0 for 33 cycles, then rd_valid=1 with the remainder.
- Assert reset at cycle 10 of a DIV -> busy=0, hi=lo=0 next cycle. A start during busy has no effect on the in-flight result.
